note_tone_gen: RTL and testbench
================================

# note_tone_gen

Downstream consumer of the ultrasonic ranging stage's one-hot `note[9:0]` bus. It samples the note code at the ranging frame rate and debounces it over several frames so sensor jitter does not chirp the speaker. It then drives a 50 %-duty square wave on the buzzer pin at the pitch of the accepted note, C4 through E5 in C major. It is the last stage before the board buzzer pin.

## Interface
- `SAMPLE_DIV`, 1250000: s_clk cycles per note sample (matches the ranging frame period at 100 MHz).
- `STABLE_CNT`, 4: number of consecutive identical samples required before a note is accepted (range 1..15).
- `TONE_SHIFT`, 0: right-shift applied to every half-period constant (simulation speed-up only).
- `s_clk`  input  1  system clock, 100 MHz.
- `s_rst_n`  input  1  reset, asynchronous, active-low.
- `note`  input  10  one-hot note request from the ranging stage; all-zero means silence.
- `enable`  input  1  sound enable; low forces silence without disturbing the debounce.
- `buzzer`  output  1  square-wave drive to the buzzer; registered.
- `note_active`  output  10  currently accepted note (one-hot or zero); registered.
- `playing`  output  1  high while `enable` is high and `note_active` is non-zero; registered.

## Operation
- Sample timer: `samp_cnt` counts 0..SAMPLE_DIV-1 and wraps. `samp_tick` is high on the cycle where `samp_cnt == SAMPLE_DIV-1`.
- Validation: on `samp_tick`, `note` is sampled. Any value with more than one bit set is treated as 10'b0 (silence).
- Debounce, updated only on `samp_tick`:
  - If the validated sample equals `cand`, then `stab_cnt` increments, saturating at STABLE_CNT.
  - Otherwise `cand` takes the sample and `stab_cnt` becomes 1.
  - When the post-update `stab_cnt == STABLE_CNT` and `cand != note_active`, `note_active` takes `cand` on the same tick.
  - STABLE_CNT = 1 accepts every sample directly.
- Half-period table, in s_clk cycles, shifted right by TONE_SHIFT, 18-bit:
  - bit0 C4 191110, bit1 D4 170265, bit2 E4 151685, bit3 F4 143172, bit4 G4 127551.
  - bit5 A4 113636, bit6 B4 101239, bit7 C5 95557, bit8 D5 85131, bit9 E5 75844.
  - If `note_active` is zero, `half_per` is 0.
- Tone FSM, two states:
  - SILENT: `buzzer` = 0 and `tone_cnt` = 0. Move to TONE when `enable` is high and `note_active` is non-zero.
  - TONE: `tone_cnt` increments each cycle. When `tone_cnt == half_per-1`, `buzzer` toggles and `tone_cnt` clears.
  - TONE returns to SILENT when `enable` is low or `note_active` becomes zero.
  - If `note_active` changes to a different non-zero note while in TONE, stay in TONE, clear `tone_cnt` and force `buzzer` to 0. This is a phase restart.
- `playing` = registered (`enable` & |`note_active`).
- Reset values: `samp_cnt`, `stab_cnt`, `cand`, `note_active`, `tone_cnt` and `buzzer` all 0; `playing` 0; FSM in SILENT.

## Timing
- Acceptance latency: a new stable input is visible on `note_active` at the STABLE_CNT-th `samp_tick` after its first sample, +1 cycle for the register.
- The first `buzzer` rise comes half_per cycles after the cycle in which the FSM enters TONE or restarts phase. The output period is 2·half_per cycles.
- Precedence within a cycle:
  1. Reset.
  2. `enable` low, which silences on the next edge.
  3. `note_active` change, which restarts phase and overrides a coincident toggle.
  4. Toggle.
- Input glitches shorter than STABLE_CNT samples never reach `note_active`. Debounce state keeps running while `enable` is low.
- Asserting `s_rst_n` mid-tone drops `buzzer` to 0 immediately (asynchronous).

## Test plan
- Reset/idle: hold `note`=0 and `enable`=1 for 10 ticks (SAMPLE_DIV=8, STABLE_CNT=3, TONE_SHIFT=8) -> `buzzer`, `note_active` and `playing` stay 0.
- Accept and pitch: `note`=10'b0000100000 held -> `note_active`=0x020 at the 3rd tick. `buzzer` toggles every 113636>>8 = 443 cycles (period 886), and `playing`=1.
- Glitch rejection: stable A4 accepted, then `note`=0x001 for 2 ticks, then back to 0x020 -> `note_active` stays 0x020 and `buzzer` is uninterrupted.
- Invalid code: `note`=10'b0000000011 for 5 ticks -> treated as silence; `note_active`=0 after 3 ticks and `buzzer`=0.
- Change and enable: switch A4 to E5 (0x200) -> phase restart, `buzzer`=0, then toggles every 75844>>8 = 296 cycles. Drop `enable` mid-period -> `buzzer`=0 on the next edge. Raise it again -> tone resumes from `tone_cnt`=0.
- Async reset mid-tone: assert `s_rst_n`=0 between clock edges -> `buzzer`, `note_active` and `playing` go to 0 immediately.

Source files
------------

// File: rtl/note_tone_gen_if.sv
// Note-request / buzzer bundle between the ranging stage, the tone generator and the board pin.
interface note_tone_gen_if;
    logic [9:0] note;
    logic       enable;
    logic       buzzer;
    logic [9:0] note_active;
    logic       playing;

    modport master (output note, enable, input buzzer, note_active, playing);
    modport slave  (input note, enable, output buzzer, note_active, playing);
endinterface

// File: rtl/note_tone_gen.sv
// Debounces the one-hot note request at the sample rate and drives a 50 % duty
// square wave on the buzzer at the pitch of the accepted note.
module note_tone_gen #(
    parameter int SAMPLE_DIV = 1250000,
    parameter int STABLE_CNT = 4,
    parameter int TONE_SHIFT = 0
) (
    input  logic           s_clk,
    input  logic           s_rst_n,
    note_tone_gen_if.slave bus
);
    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [3:0] STAB = 4'(STABLE_CNT);
    localparam logic [17:0] HP_TABLE [10] = '{
        18'd191110, 18'd170265, 18'd151685, 18'd143172, 18'd127551,
        18'd113636, 18'd101239, 18'd95557,  18'd85131,  18'd75844
    };

    typedef enum logic {SILENT, TONE} state_t;

    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic          samp_tick;
    logic [9:0]    samp_note;
    logic [9:0]    cand_q, cand_d;
    logic [3:0]    stab_q, stab_d;
    logic [9:0]    note_active_q, note_active_d;
    logic [17:0]   half_per;
    state_t        state_q, state_d;
    logic [17:0]   tone_cnt_q, tone_cnt_d;
    logic          buzzer_q, buzzer_d;
    logic          playing_q, playing_d;

    always_comb begin
        samp_tick  = (samp_cnt_q == SW'(SAMPLE_DIV - 1));
        samp_cnt_d = samp_tick ? '0 : samp_cnt_q + 1'b1;
        // Multi-bit codes are sensor garbage; treat them as a request for silence.
        samp_note  = $onehot0(bus.note) ? bus.note : '0;
    end

    always_comb begin
        cand_d        = cand_q;
        stab_d        = stab_q;
        note_active_d = note_active_q;
        if (samp_tick) begin
            if (samp_note == cand_q) begin
                if (stab_q != STAB) stab_d = stab_q + 4'd1;
            end else begin
                cand_d = samp_note;
                stab_d = 4'd1;
            end
            if (stab_d == STAB && cand_d != note_active_q) note_active_d = cand_d;
        end
    end

    always_comb begin
        half_per = '0;
        for (int i = 0; i < 10; i++)
            if (note_active_q[i]) half_per = HP_TABLE[i] >> TONE_SHIFT;
    end

    always_comb begin
        state_d    = state_q;
        tone_cnt_d = tone_cnt_q;
        buzzer_d   = buzzer_q;
        playing_d  = bus.enable & (|note_active_q);
        case (state_q)
            SILENT: begin
                tone_cnt_d = '0;
                buzzer_d   = 1'b0;
                if (bus.enable && note_active_q != '0) state_d = TONE;
            end
            TONE: begin
                if (!bus.enable || note_active_q == '0) begin
                    state_d    = SILENT;
                    tone_cnt_d = '0;
                    buzzer_d   = 1'b0;
                end else if (note_active_d != note_active_q && note_active_d != '0) begin
                    // Restart lands on the same edge that loads the new note.
                    tone_cnt_d = '0;
                    buzzer_d   = 1'b0;
                end else if (tone_cnt_q == half_per - 18'd1) begin
                    tone_cnt_d = '0;
                    buzzer_d   = ~buzzer_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 18'd1;
                end
            end
            default: state_d = SILENT;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            samp_cnt_q    <= '0;
            cand_q        <= '0;
            stab_q        <= '0;
            note_active_q <= '0;
            state_q       <= SILENT;
            tone_cnt_q    <= '0;
            buzzer_q      <= 1'b0;
            playing_q     <= 1'b0;
        end else begin
            samp_cnt_q    <= samp_cnt_d;
            cand_q        <= cand_d;
            stab_q        <= stab_d;
            note_active_q <= note_active_d;
            state_q       <= state_d;
            tone_cnt_q    <= tone_cnt_d;
            buzzer_q      <= buzzer_d;
            playing_q     <= playing_d;
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.note_active = note_active_q;
    assign bus.playing     = playing_q;
endmodule

// File: tb/tb_note_tone_gen.sv
// Directed plus random stimulus for note_tone_gen, checked every cycle against a
// sample-history / elapsed-time reference model.
module tb_note_tone_gen;
    localparam int SAMPLE_DIV = 8;
    localparam int STABLE_CNT = 3;
    localparam int TONE_SHIFT = 8;
    localparam int HP_FULL [10] = '{191110, 170265, 151685, 143172, 127551,
                                    113636, 101239, 95557, 85131, 75844};

    logic s_clk = 1'b0;
    logic s_rst_n;
    note_tone_gen_if bus ();

    note_tone_gen #(.SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT), .TONE_SHIFT(TONE_SHIFT))
        dut (.s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus));

    always #5 s_clk = ~s_clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    int         cyc;
    logic [9:0] m_na;
    logic       m_tone;
    logic       m_play;
    int         ph_start;
    int         ph_hp;
    logic [9:0] hist [$];

    function automatic int hp_of(input logic [9:0] n);
        int r = 0;
        for (int i = 0; i < 10; i++) if (n[i]) r = HP_FULL[i] >> TONE_SHIFT;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        cyc = 0; m_na = '0; m_tone = 1'b0; m_play = 1'b0;
        ph_start = 0; ph_hp = 1;
        hist.delete();
    endtask

    task automatic tick_cycle();
        logic [9:0] old_na, v;
        logic       en, same;
        logic       exp_buz;
        @(posedge s_clk);
        en = bus.enable;
        cyc++;
        old_na = m_na;
        if (cyc % SAMPLE_DIV == 0) begin
            v = $onehot0(bus.note) ? bus.note : 10'h000;
            hist.push_back(v);
            if (hist.size() > STABLE_CNT) void'(hist.pop_front());
            same = (hist.size() == STABLE_CNT);
            foreach (hist[i]) if (hist[i] != v) same = 1'b0;
            if (same) m_na = v;
        end
        if (m_tone) begin
            if (!en || old_na == 0) m_tone = 1'b0;
            else if (m_na != old_na && m_na != 0) begin
                ph_start = cyc; ph_hp = hp_of(m_na);
            end
        end else if (en && old_na != 0) begin
            m_tone = 1'b1; ph_start = cyc; ph_hp = hp_of(old_na);
        end
        m_play  = en && (old_na != 0);
        exp_buz = m_tone ? 1'(((cyc - ph_start) / ph_hp) % 2) : 1'b0;
        #1;
        check("note_active", 32'(bus.note_active), 32'(m_na));
        check("playing", 32'(bus.playing), 32'(m_play));
        check("buzzer", 32'(bus.buzzer), 32'(exp_buz));
    endtask

    // Runs until n sample ticks have elapsed, ending right after a tick edge.
    task automatic run_ticks(input int n);
        repeat (n) begin
            do tick_cycle(); while (cyc % SAMPLE_DIV != 0);
        end
    endtask

    task automatic cycles_to_buzz(input logic lvl, input int bound, output int n);
        n = 0;
        while (bus.buzzer !== lvl && n < bound) begin
            tick_cycle();
            n++;
        end
    endtask

    initial begin
        int n, r, hold;
        s_rst_n    = 1'b0;
        bus.note   = '0;
        bus.enable = 1'b0;
        model_reset();
        #23;
        check("rst_buzzer", 32'(bus.buzzer), 32'd0);
        check("rst_note_active", 32'(bus.note_active), 32'd0);
        check("rst_playing", 32'(bus.playing), 32'd0);
        #4 s_rst_n = 1'b1;

        // Idle with silence requested
        bus.enable = 1'b1;
        run_ticks(10);
        check("idle_note_active", 32'(bus.note_active), 32'd0);

        // Accept A4 and measure pitch
        bus.note = 10'h020;
        run_ticks(3);
        check("accept_a4", 32'(bus.note_active), 32'h020);
        cycles_to_buzz(1'b1, 2000, n);
        cycles_to_buzz(1'b0, 2000, n);
        check("a4_half_fall", 32'(n), 32'd443);
        cycles_to_buzz(1'b1, 2000, n);
        check("a4_half_rise", 32'(n), 32'd443);

        // Short glitch never reaches note_active
        bus.note = 10'h001;
        run_ticks(2);
        bus.note = 10'h020;
        run_ticks(4);
        check("glitch_hold", 32'(bus.note_active), 32'h020);

        // Multi-bit code means silence
        bus.note = 10'h003;
        run_ticks(3);
        check("invalid_silence", 32'(bus.note_active), 32'd0);
        tick_cycle();
        check("invalid_buzzer", 32'(bus.buzzer), 32'd0);
        run_ticks(2);

        // A4 -> E5 phase restart, then enable drop and resume
        bus.note = 10'h020;
        run_ticks(3);
        repeat (500) tick_cycle();
        bus.note = 10'h200;
        run_ticks(3);
        check("accept_e5", 32'(bus.note_active), 32'h200);
        check("restart_buzzer", 32'(bus.buzzer), 32'd0);
        cycles_to_buzz(1'b1, 2000, n);
        check("e5_first_rise", 32'(n), 32'd296);
        cycles_to_buzz(1'b0, 2000, n);
        check("e5_half_fall", 32'(n), 32'd296);
        repeat (100) tick_cycle();
        bus.enable = 1'b0;
        tick_cycle();
        check("disable_buzzer", 32'(bus.buzzer), 32'd0);
        repeat (50) tick_cycle();
        bus.enable = 1'b1;
        // One edge to re-enter the tone state, then a full half period.
        cycles_to_buzz(1'b1, 2000, n);
        check("resume_rise", 32'(n), 32'd297);

        // Asynchronous reset while the buzzer is high
        #2 s_rst_n = 1'b0;
        #1;
        check("async_buzzer", 32'(bus.buzzer), 32'd0);
        check("async_note_active", 32'(bus.note_active), 32'd0);
        check("async_playing", 32'(bus.playing), 32'd0);
        model_reset();
        #3 s_rst_n = 1'b1;

        // Random note / enable segments
        for (int seg = 0; seg < 30; seg++) begin
            r = $urandom_range(0, 11);
            if (r < 10)       bus.note = 10'h001 << r;
            else if (r == 10) bus.note = 10'h000;
            else              bus.note = 10'($urandom);
            bus.enable = ($urandom_range(0, 4) != 0);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 5);
            run_ticks(hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
